// File: rtl/aes_pkg.sv
// Shared AES definitions: round count default, state type, FSM encodings,
// S-box tables and byte-level transforms used by the round datapath.
// AES_DEC_EN: when defined, the inverse S-box and inverse shift are also provided.
package aes_pkg;

    localparam int unsigned AES_NR       = 10;
    localparam int unsigned AES_RK_IDX_W = 4;

    typedef logic [127:0]      aes_state_t;
    // Byte view of the state: element 0 is the most significant byte.
    typedef logic [0:15][7:0]  aes_bytes_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_bytes_t i_b;
        aes_bytes_t o_b;
        i_b = aes_bytes_t'(s);
        for (int i = 0; i < 16; i++) begin
            o_b[4'(i)] = SBOX[i_b[4'(i)]];
        end
        return aes_state_t'(o_b);
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_bytes_t i_b;
        aes_bytes_t o_b;
        i_b = aes_bytes_t'(s);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o_b[4'(r + 4 * c)] = i_b[4'(r + 4 * ((c + r) % 4))];
            end
        end
        return aes_state_t'(o_b);
    endfunction

`ifdef AES_DEC_EN
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_bytes_t i_b;
        aes_bytes_t o_b;
        i_b = aes_bytes_t'(s);
        for (int i = 0; i < 16; i++) begin
            o_b[4'(i)] = INV_SBOX[i_b[4'(i)]];
        end
        return aes_state_t'(o_b);
    endfunction

    // Row r rotates right by r columns.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_bytes_t i_b;
        aes_bytes_t o_b;
        i_b = aes_bytes_t'(s);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o_b[4'(r + 4 * c)] = i_b[4'(r + 4 * ((c - r + 4) % 4))];
            end
        end
        return aes_state_t'(o_b);
    endfunction
`endif

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES round.
//   enc: MixColumns(ShiftRows(SubBytes(st))) ^ rk, MixColumns skipped when last
//   dec: InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk), InvMixColumns skipped when last
// Ports: st (current state), rk (round key), dec (inverse round), last (final round), nxt.
// AES_DEC_EN: builds the inverse path; otherwise dec is ignored.
module aes_round_step
    import aes_pkg::*;
(
    input  aes_state_t st,
    input  aes_state_t rk,
    input  logic       dec,
    input  logic       last,
    output aes_state_t nxt
);

    aes_state_t enc_sr;
    aes_state_t enc_mc;
    aes_state_t enc_nxt;

    assign enc_sr = shift_rows(sub_bytes(st));

    mix_columns #(.EN(1'b1)) u_mix_fwd (
        .st    (enc_sr),
        .mixed (enc_mc)
    );

    assign enc_nxt = (last ? enc_sr : enc_mc) ^ rk;

`ifdef AES_DEC_EN
    aes_state_t dec_ark;
    aes_state_t dec_imc;

    assign dec_ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;

    mix_columns #(.EN(1'b0)) u_mix_inv (
        .st    (dec_ark),
        .mixed (dec_imc)
    );

    assign nxt = dec ? (last ? dec_ark : dec_imc) : enc_nxt;
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign nxt        = enc_nxt;
`endif

endmodule

// File: rtl/mix_columns.sv
// Column mixing over all four state columns.
//   EN=1: forward MixColumns (coefficients 02 03 01 01)
//   EN=0: InvMixColumns      (coefficients 0e 0b 0d 09)
// Ports: st (state in), mixed (state out). Purely combinational.
module mix_columns
    import aes_pkg::*;
#(
    parameter bit EN = 1'b1
) (
    input  aes_state_t st,
    output aes_state_t mixed
);

    // Circulant row coefficients; output row r uses COEF[k] on input row (r+k)%4.
    localparam logic [0:3][3:0] COEF = EN ? 16'h2311 : 16'hebd9;

    // Multiply by a 4-bit constant built from x, x^2, x^3 partial products.
    function automatic logic [7:0] gf_mul4(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & b2) ^ ({8{k[2]}} & b4) ^ ({8{k[3]}} & b8);
    endfunction

    aes_bytes_t in_b;
    aes_bytes_t out_b;
    logic [7:0] acc;

    assign in_b  = aes_bytes_t'(st);
    assign mixed = aes_state_t'(out_b);

    always_comb begin
        out_b = '0;
        acc   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul4(in_b[4'(((r + k) % 4) + 4 * c)], COEF[2'(k)]);
                end
                out_b[4'(r + 4 * c)] = acc;
            end
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES block engine: one round per clock through aes_round_step,
// round keys fetched by index from an external key store, valid/ready on both sides.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input block handshake; in_data block, in_dec mode (sampled on accept)
//   rk_idx/rk_data           round-key request (combinational) and same-cycle key return
//   out_valid/out_ready      result handshake; out_data held while out_valid
//   busy                     high from accept until the result is taken
// AES_DEC_EN: enables the decrypt datapath; otherwise in_dec is ignored.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR       = AES_NR,
    parameter int unsigned RK_IDX_W = AES_RK_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic                in_dec,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RND_PRE = RK_IDX_W'(NR - 1);

    logic [1:0]          fsm;
    logic [1:0]          fsm_nxt;
    logic [RK_IDX_W-1:0] rnd;
    logic                mode_dec;
    logic                dec_req;
    logic                accept;
    aes_state_t          st;
    aes_state_t          step_nxt;

`ifdef AES_DEC_EN
    assign dec_req = in_dec;
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
    assign dec_req       = 1'b0;
`endif

    assign accept   = in_valid && in_ready;
    assign out_data = st;

    aes_round_step u_step (
        .st   (st),
        .rk   (rk_data),
        .dec  (mode_dec),
        .last (fsm == ST_FINAL),
        .nxt  (step_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= ST_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            ST_IDLE:  if (accept) fsm_nxt = (NR == 1) ? ST_FINAL : ST_ROUND;
            ST_ROUND: if (rnd == RND_PRE) fsm_nxt = ST_FINAL;
            ST_FINAL: fsm_nxt = ST_DONE;
            ST_DONE:  if (out_ready) fsm_nxt = ST_IDLE;
            default:  fsm_nxt = ST_IDLE;
        endcase
    end

    // Round-key index; in IDLE it follows in_dec so the whitening key is ready at accept.
    always_comb begin
        rk_idx = '0;
        case (fsm)
            ST_IDLE:  rk_idx = dec_req ? RK_LAST : '0;
            ST_ROUND: rk_idx = mode_dec ? (RK_LAST - rnd) : rnd;
            ST_FINAL: rk_idx = mode_dec ? '0 : RK_LAST;
            default:  rk_idx = '0;
        endcase
    end

    // Datapath and handshake flags; flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            rnd       <= '0;
            mode_dec  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (fsm_nxt == ST_DONE);
            busy      <= (fsm_nxt != ST_IDLE);
            in_ready  <= (fsm_nxt == ST_IDLE);
            case (fsm)
                ST_IDLE: begin
                    if (accept) begin
                        st       <= in_data ^ rk_data;
                        mode_dec <= dec_req;
                        rnd      <= RK_IDX_W'(1);
                    end
                end
                ST_ROUND, ST_FINAL: begin
                    st  <= step_nxt;
                    rnd <= rnd + RK_IDX_W'(1);
                end
                default: begin
                    if (out_ready) rnd <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched with a byte-level AES-128 reference model.
// AES_DEC_EN: when defined, decrypt blocks are exercised as well.
module tb_aes_round_sched;

    localparam int unsigned NR = 10;

    typedef logic [0:15][7:0] blk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_dec;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk_tab [16];
    logic [7:0]   sb     [256];
    logic [7:0]   isb    [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Key store: returns the addressed round key in the same cycle.
    assign rk_data = rk_tab[rk_idx];

    aes_round_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dec    (in_dec),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[8'(x)]  = s;
            isb[s]     = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[6'(i)] = key[7'(127 - 32 * i) -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[6'(i - 1)];
            if (i % 4 == 0) begin
                t    = {t[23:0], t[31:24]};
                t    = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[6'(i)] = w[6'(i - 4)] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= int'(NR)) rk_tab[4'(r)] = {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
            else               rk_tab[4'(r)] = '0;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        blk_t s;
        blk_t t;
        logic [7:0] a [4];
        s = blk_t'(pt) ^ blk_t'(rk_tab[0]);
        for (int rr = 1; rr <= int'(NR); rr++) begin
            for (int i = 0; i < 16; i++) t[4'(i)] = sb[s[4'(i)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4'(r + 4 * c)] = t[4'(r + 4 * ((c + r) % 4))];
            if (rr < int'(NR)) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[2'(j)] = s[4'(j + 4 * c)];
                    for (int r = 0; r < 4; r++)
                        s[4'(r + 4 * c)] = gf_mul(a[2'(r)], 8'h02) ^ gf_mul(a[2'((r + 1) % 4)], 8'h03)
                                         ^ a[2'((r + 2) % 4)] ^ a[2'((r + 3) % 4)];
                end
            end
            s = s ^ blk_t'(rk_tab[4'(rr)]);
        end
        return 128'(s);
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct);
        blk_t s;
        blk_t t;
        logic [7:0] a [4];
        s = blk_t'(ct) ^ blk_t'(rk_tab[4'(NR)]);
        for (int rr = int'(NR) - 1; rr >= 0; rr--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4'(r + 4 * ((c + r) % 4))] = s[4'(r + 4 * c)];
            for (int i = 0; i < 16; i++) s[4'(i)] = isb[t[4'(i)]];
            s = s ^ blk_t'(rk_tab[4'(rr)]);
            if (rr > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[2'(j)] = s[4'(j + 4 * c)];
                    for (int r = 0; r < 4; r++)
                        s[4'(r + 4 * c)] = gf_mul(a[2'(r)], 8'h0e) ^ gf_mul(a[2'((r + 1) % 4)], 8'h0b)
                                         ^ gf_mul(a[2'((r + 2) % 4)], 8'h0d) ^ gf_mul(a[2'((r + 3) % 4)], 8'h09);
                end
            end
        end
        return 128'(s);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Offer one block from IDLE and follow it to DONE, checking key indices and latency.
    task automatic do_block(input string tag, input logic [127:0] din, input logic dec, input logic [127:0] exp);
        logic dec_eff;
`ifdef AES_DEC_EN
        dec_eff = dec;
`else
        dec_eff = 1'b0;
`endif
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        in_data  = din;
        in_dec   = dec;
        in_valid = 1'b1;
        chki({tag, "_rk_idle"}, int'(rk_idx), dec_eff ? int'(NR) : 0);
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        in_dec   = 1'($urandom_range(0, 1));
        for (int i = 1; i <= int'(NR); i++) begin
            chk1({tag, "_no_early_valid"}, out_valid, 1'b0);
            chk1({tag, "_busy"}, busy, 1'b1);
            chki({tag, "_rk_seq"}, int'(rk_idx), dec_eff ? int'(NR) - i : i);
            tick();
        end
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, exp);
        chk1({tag, "_ready_low"}, in_ready, 1'b0);
        chki({tag, "_rk_done"}, int'(rk_idx), 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({tag, "_hs_valid"}, out_valid, 1'b0);
        chk1({tag, "_hs_ready"}, in_ready, 1'b1);
        chk1({tag, "_hs_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        logic         dm;
        logic [127:0] exp_q [$];
        int           acc_cyc [$];
        int           n_out;
        logic         acc_now;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        build_sbox();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);

        // Reset values
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 128'h0);
        chki("rst_rk_idx", int'(rk_idx), 0);

        // Known-answer encryption
        do_block("fips_enc", 128'h00112233445566778899aabbccddeeff, 1'b0,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        handshake("fips_enc");

`ifdef AES_DEC_EN
        do_block("fips_dec", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
                 128'h00112233445566778899aabbccddeeff);
`else
        do_block("enc_only", 128'h00112233445566778899aabbccddeeff, 1'b1,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
`endif
        handshake("mode2");

        // Backpressure in DONE: output held, extra offers ignored
        d = rand128();
        e = ref_enc(d);
        do_block("bp", d, 1'b0, e);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
            chk1("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, e);
            chk1("bp_hold_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_before_release", out_data, e);
        handshake("bp");
        tick();
        chk1("bp_idle_valid", out_valid, 1'b0);
        chk1("bp_idle_busy", busy, 1'b0);

        // Back-to-back with in_valid held and consumer always ready
        expand_key(rand128());
        in_dec    = 1'b0;
        in_data   = rand128();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_out     = 0;
        for (int cyc = 0; cyc < 3 * (int'(NR) + 2) + 4; cyc++) begin
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(ref_enc(in_data));
            end
            if (out_valid) begin
                n_out++;
                if (exp_q.size() > 0) chk("b2b_data", out_data, exp_q.pop_front());
                else                  chk1("b2b_spurious_valid", out_valid, 1'b0);
            end
            tick();
            if (acc_now) begin
                in_data = rand128();
                if (acc_cyc.size() == 3) in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        chki("b2b_accepts", acc_cyc.size(), 3);
        chki("b2b_outputs", n_out, 3);
        if (acc_cyc.size() == 3) begin
            chki("b2b_gap1", acc_cyc[1] - acc_cyc[0], int'(NR) + 2);
            chki("b2b_gap2", acc_cyc[2] - acc_cyc[1], int'(NR) + 2);
        end

        // Reset in the middle of a block
        in_data  = rand128();
        in_dec   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chki("mid_rk_idx", int'(rk_idx), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b1);
        d = rand128();
        do_block("post_rst", d, 1'b0, ref_enc(d));
        handshake("post_rst");

        // Random keys, blocks, modes and consumer stalls
        for (int b = 0; b < 6; b++) begin
            expand_key(rand128());
            d  = rand128();
`ifdef AES_DEC_EN
            dm = 1'($urandom_range(0, 1));
            e  = dm ? ref_dec(d) : ref_enc(d);
`else
            dm = 1'($urandom_range(0, 1));
            e  = ref_enc(d);
`endif
            do_block("rand", d, dm, e);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                chk("rand_stall_data", out_data, e);
                tick();
            end
            handshake("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
